// File: rtl/a2d_scan.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_scan
//  Description : SPI master that scans a list of ADC128S channels and holds
//                the latest 12-bit result and a valid flag per channel slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module a2d_scan #(
    parameter int                  NUM_CH   = 3,
    parameter logic [NUM_CH*3-1:0] CH_LIST  = {3'd5, 3'd4, 3'd0},
    parameter int                  SCLK_DIV = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 strt_scan,
    input  logic                 cont_en,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic [NUM_CH*12-1:0] res,
    output logic [NUM_CH-1:0]    vld,
    output logic                 busy,
    output logic                 scan_done
);

    localparam int            c_cw       = $clog2(SCLK_DIV);
    localparam int            c_iw       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_cw-1:0] c_cnt_max = '1;
    localparam logic [c_cw-1:0] c_half_m1 = c_cw'(SCLK_DIV / 2 - 1);
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX1  = 3'd1,
        S_GAP1 = 3'd2,
        S_TX2  = 3'd3,
        S_GAP2 = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic [3:0]      r_bit_cnt;
    logic [c_iw-1:0] r_idx;
    logic [15:0]     r_tx;
    logic [15:0]     r_rx;

    logic            w_gap_end;
    logic            w_launch;
    logic [c_iw-1:0] w_slot;
    logic [15:0]     w_frame;

    function automatic logic [15:0] frame_of(input logic [c_iw-1:0] slot);
        return {2'b00, CH_LIST[3*int'(slot) +: 3], 11'h000};
    endfunction

    // A launch starts a frame on the next edge; w_slot picks whose channel.
    always_comb begin
        w_gap_end = ((r_state == S_GAP1) || (r_state == S_GAP2)) && (r_cnt == c_cnt_max);
        w_launch  = 1'b0;
        w_slot    = r_idx;
        case (r_state)
            S_IDLE: begin
                w_launch = strt_scan;
                w_slot   = '0;
            end
            S_GAP1: w_launch = w_gap_end;
            S_GAP2: begin
                if (r_idx != c_last_idx) begin
                    w_launch = w_gap_end;
                    w_slot   = r_idx + c_iw'(1);
                end else begin
                    w_launch = w_gap_end && cont_en;
                    w_slot   = '0;
                end
            end
            default: w_launch = 1'b0;
        endcase
        w_frame = frame_of(w_slot);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            res       <= '0;
            vld       <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (strt_scan) begin
                        r_state <= S_TX1;
                        busy    <= 1'b1;
                        vld     <= '0;
                        r_idx   <= '0;
                    end
                end
                S_TX1, S_TX2: begin
                    r_cnt <= r_cnt + c_cw'(1);
                    if (r_cnt == c_half_m1) begin
                        SCLK <= 1'b1;
                        r_rx <= {r_rx[14:0], MISO};
                    end else if (r_cnt == c_cnt_max) begin
                        if (r_bit_cnt == 4'd15) begin
                            // Frame ends with SCLK left high; result of TX2 lands here.
                            SS_n <= 1'b1;
                            MOSI <= 1'b0;
                            if (r_state == S_TX2) begin
                                r_state                   <= S_GAP2;
                                res[12*int'(r_idx) +: 12] <= r_rx[11:0];
                                vld[r_idx]                <= 1'b1;
                                scan_done                 <= (r_idx == c_last_idx);
                            end else begin
                                r_state <= S_GAP1;
                            end
                        end else begin
                            SCLK      <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            MOSI      <= r_tx[15];
                            r_tx      <= {r_tx[14:0], 1'b0};
                        end
                    end
                end
                S_GAP1: begin
                    r_cnt <= r_cnt + c_cw'(1);
                    if (w_gap_end) begin
                        r_state <= S_TX2;
                    end
                end
                S_GAP2: begin
                    r_cnt <= r_cnt + c_cw'(1);
                    if (w_gap_end) begin
                        if (r_idx != c_last_idx) begin
                            r_idx   <= r_idx + c_iw'(1);
                            r_state <= S_TX1;
                        end else if (cont_en) begin
                            r_idx   <= '0;
                            r_state <= S_TX1;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_launch) begin
                SS_n      <= 1'b0;
                SCLK      <= 1'b0;
                MOSI      <= w_frame[15];
                r_tx      <= {w_frame[14:0], 1'b0};
                r_cnt     <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_a2d_scan
//  Description : Directed self-checking bench for a2d_scan with an ADC128S model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_scan;

    localparam int SCAN_CLKS = 3264;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, strt_scan, cont_en, MISO;
    logic        SS_n, SCLK, MOSI, busy, scan_done;
    logic [35:0] res;
    logic [2:0]  vld;

    logic        rst2_n, strt2, MISO2;
    logic        SS2_n, SCLK2, MOSI2, busy2, done2;
    logic [11:0] res2;
    logic [0:0]  vld2;

    a2d_scan #(.NUM_CH(3), .CH_LIST(9'b101_100_000), .SCLK_DIV(32)) dut (
        .clk(clk), .rst_n(rst_n), .strt_scan(strt_scan), .cont_en(cont_en),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .res(res), .vld(vld), .busy(busy), .scan_done(scan_done)
    );

    a2d_scan #(.NUM_CH(1), .CH_LIST(3'd5), .SCLK_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .strt_scan(strt2), .cont_en(1'b0),
        .SS_n(SS2_n), .SCLK(SCLK2), .MOSI(MOSI2), .MISO(MISO2),
        .res(res2), .vld(vld2), .busy(busy2), .scan_done(done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model state and bus monitors
    logic [11:0] adc_val [8];
    logic [2:0]  ch_addr = 3'd0, ch_addr2 = 3'd0;
    logic [15:0] adc_in = '0, adc_out = '0, adc2_in = '0, adc2_out = '0;
    logic        ss_q = 1'b1, sclk_q = 1'b1, busy_q = 1'b0;
    logic        ss2_q = 1'b1, sclk2_q = 1'b1, busy2_q = 1'b0;
    int          cyc = 0, nrise = 0, low_start = 0;
    int          busy_rise = 0, busy_len = 0, busy2_rise = 0, busy2_len = 0;
    int          done_cnt = 0, done2_cnt = 0, last_done = 0, prev_done = 0;
    logic        vld_watch = 1'b0, vld_drop = 1'b0;
    logic [15:0] frames [$];
    int          lows [$];
    int          rises [$];

    assign MISO  = adc_out[15];
    assign MISO2 = adc2_out[15];

    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_q) busy_rise = cyc;
        if (!busy && busy_q) busy_len = cyc - busy_rise;
        busy_q = busy;
        if (busy2 && !busy2_q) busy2_rise = cyc;
        if (!busy2 && busy2_q) busy2_len = cyc - busy2_rise;
        busy2_q = busy2;
        if (scan_done) begin
            prev_done = last_done;
            last_done = cyc;
            done_cnt++;
        end
        if (done2) done2_cnt++;
        if (vld_watch && vld != 3'b111) vld_drop = 1'b1;

        if (ss_q && !SS_n) begin
            adc_out   = {4'h0, adc_val[ch_addr]};
            adc_in    = '0;
            nrise     = 0;
            low_start = cyc;
        end else if (!SS_n && !sclk_q && SCLK) begin
            adc_in  = {adc_in[14:0], MOSI};
            adc_out = {adc_out[14:0], 1'b0};
            nrise++;
        end
        if (!ss_q && SS_n) begin
            ch_addr = adc_in[13:11];
            frames.push_back(adc_in);
            lows.push_back(cyc - low_start);
            rises.push_back(nrise);
        end
        ss_q   = SS_n;
        sclk_q = SCLK;

        if (ss2_q && !SS2_n) begin
            adc2_out = {4'h0, adc_val[ch_addr2]};
            adc2_in  = '0;
        end else if (!SS2_n && !sclk2_q && SCLK2) begin
            adc2_in  = {adc2_in[14:0], MOSI2};
            adc2_out = {adc2_out[14:0], 1'b0};
        end
        if (!ss2_q && SS2_n) ch_addr2 = adc2_in[13:11];
        ss2_q   = SS2_n;
        sclk2_q = SCLK2;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        frames.delete();
        lows.delete();
        rises.delete();
        done_cnt  = 0;
        done2_cnt = 0;
        busy_len  = 0;
        busy2_len = 0;
    endtask

    task automatic pulse_start();
        strt_scan = 1'b1;
        tick();
        strt_scan = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        tick();
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic wait_done(input string tag, input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt >= target), 64'(1));
    endtask

    logic [15:0] exp_frames [6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_frames = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        adc_val[0] = 12'h234;
        adc_val[4] = 12'h567;
        adc_val[5] = 12'h9AB;
        rst_n = 1'b0; strt_scan = 1'b0; cont_en = 1'b0;
        rst2_n = 1'b0; strt2 = 1'b0;
        repeat (3) tick();

        check("rst_ss_n",  64'(SS_n), 64'(1));
        check("rst_sclk",  64'(SCLK), 64'(1));
        check("rst_mosi",  64'(MOSI), 64'(0));
        check("rst_res",   64'(res), 64'(0));
        check("rst_vld",   64'(vld), 64'(0));
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(scan_done), 64'(0));
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();

        // Single-shot scan with frame checks
        clear_mon();
        pulse_start();
        check("busy_rise", 64'(busy), 64'(1));
        wait_idle("single_idle", 4000);
        check("single_res",  64'(res), 64'({12'h9AB, 12'h567, 12'h234}));
        check("single_vld",  64'(vld), 64'(3'b111));
        check("single_done", 64'(done_cnt), 64'(1));
        check("single_busy_len", 64'(busy_len), 64'(SCAN_CLKS));
        check("frame_count", 64'(frames.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < frames.size()) begin
                check($sformatf("frame%0d_mosi", i), 64'(frames[i]), 64'(exp_frames[i]));
                check($sformatf("frame%0d_low", i), 64'(lows[i]), 64'(512));
                check($sformatf("frame%0d_rises", i), 64'(rises[i]), 64'(16));
            end
        end

        // Continuous mode, batt changes between scans, then stop mid-scan
        clear_mon();
        cont_en = 1'b1;
        pulse_start();
        wait_done("cont_first_done", 1, 4000);
        adc_val[5] = 12'h7FF;
        vld_watch  = 1'b1;
        wait_done("cont_second_done", 2, 4000);
        check("cont_interval", 64'(last_done - prev_done), 64'(SCAN_CLKS));
        check("cont_batt", 64'(res[35:24]), 64'(12'h7FF));
        repeat (500) tick();
        cont_en = 1'b0;
        wait_idle("cont_stop_idle", 4000);
        vld_watch = 1'b0;
        check("cont_vld_drop", 64'(vld_drop), 64'(0));
        check("cont_done_cnt", 64'(done_cnt), 64'(3));
        check("cont_busy_len", 64'(busy_len), 64'(3 * SCAN_CLKS));
        check("cont_res", 64'(res), 64'({12'h7FF, 12'h567, 12'h234}));

        // Restart pulse while busy has no effect
        clear_mon();
        adc_val[5] = 12'h9AB;
        pulse_start();
        check("accept_clears_vld", 64'(vld), 64'(0));
        repeat (98) tick();
        pulse_start();
        wait_idle("repulse_idle", 4000);
        check("repulse_busy_len", 64'(busy_len), 64'(SCAN_CLKS));
        check("repulse_done", 64'(done_cnt), 64'(1));
        check("repulse_res", 64'(res), 64'({12'h9AB, 12'h567, 12'h234}));
        check("repulse_frames", 64'(frames.size()), 64'(6));

        // Reset during TX2 of slot 1
        clear_mon();
        pulse_start();
        repeat (1632 + 200) tick();
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        tick();
        check("mid_rst_ss_n", 64'(SS_n), 64'(1));
        check("mid_rst_sclk", 64'(SCLK), 64'(1));
        check("mid_rst_res",  64'(res), 64'(0));
        check("mid_rst_vld",  64'(vld), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        tick();
        clear_mon();
        pulse_start();
        wait_idle("post_rst_idle", 4000);
        check("post_rst_res", 64'(res), 64'({12'h9AB, 12'h567, 12'h234}));
        check("post_rst_vld", 64'(vld), 64'(3'b111));
        check("post_rst_busy_len", 64'(busy_len), 64'(SCAN_CLKS));

        // Single-channel, fast divider instance
        clear_mon();
        adc_val[5] = 12'hFFF;
        strt2 = 1'b1;
        tick();
        strt2 = 1'b0;
        begin
            int n = 0;
            while (busy2 && n < 400) begin
                tick();
                n++;
            end
        end
        tick();
        check("ch1_idle", 64'(busy2), 64'(0));
        check("ch1_res",  64'(res2), 64'(12'hFFF));
        check("ch1_vld",  64'(vld2), 64'(1));
        check("ch1_busy_len", 64'(busy2_len), 64'(136));
        check("ch1_done", 64'(done2_cnt), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
